tlb_inv_seq: RTL and testbench

- Multi-cycle sequencer for INVTLB. Walks all TLBNUM entries of the TLB array, one index per cycle.
- Evaluates the requested invalidation op against each entry's compare fields and issues a clear-E write for every matching valid entry.
- Sits beside the TLB array, driven by the WB-stage TLB control. The pipeline stalls on busy.
- Shares the TLB write port with TLBWR/TLBFILL through a grant input.

---
 rtl/tlb_inv_seq_pkg.sv | 31 +++
 rtl/tlb_inv_match.sv | 34 +++
 rtl/tlb_inv_seq.sv | 102 ++++++++++
 tb/tb_tlb_inv_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_inv_seq_pkg.sv
// Shared types for the INVTLB sequencer: walker states, op encodings and
// the per-entry compare item read from the TLB array.
package tlb_inv_seq_pkg;

  typedef enum logic [1:0] {
    INV_IDLE = 2'd0,
    INV_SCAN = 2'd1,
    INV_DONE = 2'd2
  } tlb_inv_state_e;

  localparam logic [4:0] CLEAR_ALL               = 5'd0;
  localparam logic [4:0] CLEAR_ALL_ALT           = 5'd1;
  localparam logic [4:0] CLEAR_GLOBAL            = 5'd2;
  localparam logic [4:0] CLEAR_NONGLOBAL         = 5'd3;
  localparam logic [4:0] CLEAR_NONGLOBAL_ASID    = 5'd4;
  localparam logic [4:0] CLEAR_NONGLOBAL_ASID_VA = 5'd5;
  localparam logic [4:0] CLEAR_GASID_VA          = 5'd6;
  localparam logic [4:0] INV_OP_MAX              = CLEAR_GASID_VA;

  localparam logic [5:0] PS_HUGE = 6'd21;

  // 37 bits, E in the MSB: {E, ASID, G, PS, VPPN}
  typedef struct packed {
    logic        e;
    logic [9:0]  asid;
    logic        g;
    logic [5:0]  ps;
    logic [18:0] vppn;
  } compare_item_t;

endpackage

// File: rtl/tlb_inv_match.sv
// Combinational INVTLB op predicate for one TLB entry; the vamatch term is
// shared with the TLBSRCH/lookup path.
module tlb_inv_match
  import tlb_inv_seq_pkg::*;
(
  input  logic [4:0]    op,
  input  logic [9:0]    asid,
  input  logic [18:0]   vppn,
  input  compare_item_t ci,
  output logic          hit
);

  logic vamatch;
  logic asid_eq;

  // Huge pages only carry the upper 10 VPPN bits.
  assign vamatch = (ci.ps == PS_HUGE) ? (ci.vppn[18:9] == vppn[18:9])
                                      : (ci.vppn == vppn);
  assign asid_eq = (ci.asid == asid);

  always_comb begin
    hit = 1'b0;
    case (op)
      CLEAR_ALL, CLEAR_ALL_ALT: hit = 1'b1;
      CLEAR_GLOBAL:             hit = ci.g;
      CLEAR_NONGLOBAL:          hit = !ci.g;
      CLEAR_NONGLOBAL_ASID:     hit = !ci.g && asid_eq;
      CLEAR_NONGLOBAL_ASID_VA:  hit = !ci.g && asid_eq && vamatch;
      CLEAR_GASID_VA:           hit = (ci.g || asid_eq) && vamatch;
      default:                  hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlb_inv_seq.sv
// INVTLB sequencer: walks every TLB index once and issues a clear-E write for
// each valid entry matching the latched op, sharing the write port via grant.
module tlb_inv_seq
  import tlb_inv_seq_pkg::*;
#(
  parameter int TLBNUM     = 16,
  parameter int TLBNUMSIZE = $clog2(TLBNUM)
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_op,
  input  logic [9:0]            req_asid,
  input  logic [31:0]           req_va,
  output logic [TLBNUMSIZE-1:0] tlb_idx,
  input  compare_item_t         tlb_ci,
  output logic                  inv_we,
  output logic [TLBNUMSIZE-1:0] inv_idx,
  input  logic                  inv_gnt,
  output logic                  busy,
  output logic                  done,
  output logic                  ill_op,
  output tlb_inv_state_e        dbg_state
);

  // Handshake: a request transfers on a cycle with req_valid && req_ready;
  // req_valid seen while not ready is dropped and the requester must hold it.

  localparam logic [TLBNUMSIZE-1:0] LAST_IDX = TLBNUMSIZE'(TLBNUM - 1);

  tlb_inv_state_e        state;
  logic [TLBNUMSIZE-1:0] cnt;
  logic [4:0]            op_q;
  logic [9:0]            asid_q;
  logic [18:0]           vppn_q;
  logic                  ill_q;
  logic                  hit;
  logic                  advance;
  logic                  unused_va;

  assign unused_va = ^req_va[12:0];

  tlb_inv_match u_match (
    .op   (op_q),
    .asid (asid_q),
    .vppn (vppn_q),
    .ci   (tlb_ci),
    .hit  (hit)
  );

  assign tlb_idx   = cnt;
  assign inv_idx   = cnt;
  assign inv_we    = (state == INV_SCAN) && hit && tlb_ci.e;
  // A pending clear holds the index until the write port is granted.
  assign advance   = !inv_we || inv_gnt;
  assign req_ready = (state == INV_IDLE);
  assign busy      = (state != INV_IDLE);
  assign done      = (state == INV_DONE);
  assign ill_op    = (state == INV_DONE) && ill_q;
  assign dbg_state = state;

  always_ff @(posedge aclk) begin
    if (reset) begin
      state  <= INV_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      asid_q <= '0;
      vppn_q <= '0;
      ill_q  <= 1'b0;
    end else begin
      case (state)
        INV_IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            asid_q <= req_asid;
            vppn_q <= req_va[31:13];
            cnt    <= '0;
            if (req_op > INV_OP_MAX) begin
              ill_q <= 1'b1;
              state <= INV_DONE;
            end else begin
              state <= INV_SCAN;
            end
          end
        end
        INV_SCAN: begin
          if (advance) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_IDX) state <= INV_DONE;
          end
        end
        INV_DONE: begin
          ill_q <= 1'b0;
          state <= INV_IDLE;
        end
        default: state <= INV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_inv_seq.sv
// Directed bench for tlb_inv_seq with a small TLB array model whose E bits
// are cleared on granted writes.
module tb_tlb_inv_seq;
  import tlb_inv_seq_pkg::*;

  localparam int N  = 16;
  localparam int IW = 4;

  logic           aclk = 1'b0;
  logic           reset = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [4:0]     req_op = '0;
  logic [9:0]     req_asid = '0;
  logic [31:0]    req_va = '0;
  logic [IW-1:0]  tlb_idx;
  compare_item_t  tlb_ci;
  logic           inv_we;
  logic [IW-1:0]  inv_idx;
  logic           inv_gnt = 1'b1;
  logic           busy;
  logic           done;
  logic           ill_op;
  tlb_inv_state_e dbg_state;

  compare_item_t  tlb_mem [N];
  int n_cmp = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  assign tlb_ci = tlb_mem[tlb_idx];

  tlb_inv_seq #(.TLBNUM(N)) dut (
    .aclk(aclk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_asid(req_asid), .req_va(req_va), .tlb_idx(tlb_idx),
    .tlb_ci(tlb_ci), .inv_we(inv_we), .inv_idx(inv_idx), .inv_gnt(inv_gnt),
    .busy(busy), .done(done), .ill_op(ill_op), .dbg_state(dbg_state)
  );

  // Advance one clock; the TLB model applies a granted clear on the edge.
  task automatic step();
    logic          we_s;
    logic [IW-1:0] idx_s;
    we_s  = inv_we && inv_gnt;
    idx_s = inv_idx;
    @(posedge aclk);
    if (we_s) tlb_mem[idx_s].e = 1'b0;
    #1;
  endtask

  function automatic compare_item_t mk(input logic e, input logic [9:0] asid,
                                       input logic g, input logic [5:0] ps,
                                       input logic [18:0] vppn);
    mk = {e, asid, g, ps, vppn};
  endfunction

  task automatic fill_tlb(input logic e, input logic g);
    for (int i = 0; i < N; i++) tlb_mem[i] = mk(e, 10'h3ff, g, 6'd12, 19'h7ffff);
  endtask

  task automatic run_scan(input logic [4:0] op, input logic [9:0] asid,
                          input logic [31:0] va, output int cyc, output int writes);
    writes = 0;
    req_op = op; req_asid = asid; req_va = va; req_valid = 1'b1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL accept_ready: got %b want 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      if (inv_we && inv_gnt) writes++;
      step();
      cyc++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL scan_timeout: done=%b after %0d cycles", done, cyc);
    end
    step();
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({req_ready, busy, done, ill_op, inv_we} !== 5'b10000) begin
      n_err++; $display("FAIL reset_outputs: got %b want 10000", {req_ready, busy, done, ill_op, inv_we});
    end
    n_cmp++;
    if (tlb_idx !== '0 || dbg_state !== INV_IDLE) begin
      n_err++; $display("FAIL reset_idx_state: idx %0d state %0d want 0 0", tlb_idx, dbg_state);
    end
  endtask

  task automatic test_clear_all();
    fill_tlb(1'b1, 1'b0);
    req_op = CLEAR_ALL; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (inv_we !== 1'b1 || inv_idx !== IW'(i) || busy !== 1'b1) begin
        n_err++; $display("FAIL all_walk: we %b idx %0d busy %b want 1 %0d 1", inv_we, inv_idx, busy, i);
      end
      step();
    end
    n_cmp++;
    if (done !== 1'b1 || ill_op !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL all_done: done %b ill %b busy %b want 1 0 1", done, ill_op, busy);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL all_idle: done %b ready %b want 0 1", done, req_ready);
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (tlb_mem[i].e !== 1'b0) begin
        n_err++; $display("FAIL all_cleared: entry %0d e=%b want 0", i, tlb_mem[i].e);
      end
    end
  endtask

  task automatic test_asid_va();
    int cyc, wr;
    fill_tlb(1'b0, 1'b0);
    tlb_mem[3] = mk(1'b1, 10'h005, 1'b0, 6'd12, 19'h00201);
    tlb_mem[4] = mk(1'b1, 10'h005, 1'b1, 6'd12, 19'h00201);
    tlb_mem[7] = mk(1'b1, 10'h006, 1'b0, 6'd12, 19'h00201);
    run_scan(CLEAR_NONGLOBAL_ASID_VA, 10'h005, 32'h0040_2000, cyc, wr);
    n_cmp++;
    if (cyc !== 17 || wr !== 1) begin
      n_err++; $display("FAIL op5_count: cyc %0d writes %0d want 17 1", cyc, wr);
    end
    n_cmp++;
    if ({tlb_mem[3].e, tlb_mem[4].e, tlb_mem[7].e} !== 3'b011) begin
      n_err++; $display("FAIL op5_entries: got %b want 011", {tlb_mem[3].e, tlb_mem[4].e, tlb_mem[7].e});
    end
  endtask

  task automatic test_huge_page();
    int cyc, wr;
    fill_tlb(1'b0, 1'b0);
    tlb_mem[9] = mk(1'b1, 10'h009, 1'b1, 6'd21, 19'h00200);
    run_scan(CLEAR_GASID_VA, 10'h000, 32'h0040_2000, cyc, wr);
    n_cmp++;
    if (tlb_mem[9].e !== 1'b0 || wr !== 1) begin
      n_err++; $display("FAIL op6_huge: e %b writes %0d want 0 1", tlb_mem[9].e, wr);
    end
    tlb_mem[9] = mk(1'b1, 10'h009, 1'b1, 6'd12, 19'h00200);
    run_scan(CLEAR_GASID_VA, 10'h000, 32'h0040_2000, cyc, wr);
    n_cmp++;
    if (tlb_mem[9].e !== 1'b1 || wr !== 0) begin
      n_err++; $display("FAIL op6_small: e %b writes %0d want 1 0", tlb_mem[9].e, wr);
    end
  endtask

  task automatic test_grant_stall();
    logic          exp_we;
    logic [IW-1:0] exp_idx;
    fill_tlb(1'b1, 1'b0);
    tlb_mem[2].g = 1'b1;
    req_op = CLEAR_GLOBAL; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      inv_gnt = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
      exp_we  = (c >= 3 && c <= 6);
      exp_idx = (c <= 2) ? IW'(c - 1) : (c <= 6) ? IW'(2) : IW'(c - 4);
      n_cmp++;
      if (inv_we !== exp_we || inv_idx !== exp_idx || busy !== 1'b1) begin
        n_err++; $display("FAIL stall_walk c%0d: we %b idx %0d want %b %0d", c, inv_we, inv_idx, exp_we, exp_idx);
      end
      step();
    end
    inv_gnt = 1'b1;
    n_cmp++;
    if (done !== 1'b1 || tlb_mem[2].e !== 1'b0 || tlb_mem[3].e !== 1'b1) begin
      n_err++; $display("FAIL stall_done: done %b e2 %b e3 %b want 1 0 1", done, tlb_mem[2].e, tlb_mem[3].e);
    end
    step();
  endtask

  task automatic test_illegal_op();
    fill_tlb(1'b1, 1'b0);
    req_op = 5'd7; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || ill_op !== 1'b1 || inv_we !== 1'b0) begin
      n_err++; $display("FAIL ill_done: done %b ill %b we %b want 1 1 0", done, ill_op, inv_we);
    end
    step();
    n_cmp++;
    if (req_ready !== 1'b1 || done !== 1'b0 || ill_op !== 1'b0) begin
      n_err++; $display("FAIL ill_idle: ready %b done %b ill %b want 1 0 0", req_ready, done, ill_op);
    end
    n_cmp++;
    if (tlb_mem[0].e !== 1'b1) begin
      n_err++; $display("FAIL ill_nowrite: e0 %b want 1", tlb_mem[0].e);
    end
  endtask

  task automatic test_reset_mid_scan();
    int cyc, wr;
    fill_tlb(1'b1, 1'b0);
    req_op = CLEAR_ALL; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (5) step();
    n_cmp++;
    if (inv_idx !== IW'(5)) begin
      n_err++; $display("FAIL rst_idx: got %0d want 5", inv_idx);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL rst_idle: ready %b busy %b done %b want 1 0 0", req_ready, busy, done);
    end
    n_cmp++;
    if (tlb_mem[4].e !== 1'b0 || tlb_mem[6].e !== 1'b1) begin
      n_err++; $display("FAIL rst_partial: e4 %b e6 %b want 0 1", tlb_mem[4].e, tlb_mem[6].e);
    end
    fill_tlb(1'b1, 1'b0);
    run_scan(CLEAR_NONGLOBAL, 10'h000, 32'h0, cyc, wr);
    n_cmp++;
    if (cyc !== 17 || wr !== 16) begin
      n_err++; $display("FAIL rst_rerun: cyc %0d writes %0d want 17 16", cyc, wr);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) tlb_mem[i] = '0;
    repeat (3) step();
    test_reset();
    reset = 1'b0;
    step();
    test_clear_all();
    test_asid_va();
    test_huge_page();
    test_grant_stall();
    test_illegal_op();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
